// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues sequential reads on the shared
// memory bus, queues {word, pc} pairs in a small prefetch FIFO and hands the
// head to the decoder over a valid/ready handshake. Branch redirect flushes
// the queue and reloads the PC; halt stops new fetches while the queue drains.
// Optional macro FETCH_STATS_EN adds fetch_words / stall_cycles counters.
module fetch_unit #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [WORD_SIZE-1:0]            mem_data,
  output logic                            mem_en,
  output logic                            mem_rd,
  output logic                            mem_wr,
  input  logic                            bus_gnt,
  input  logic                            halt,
  input  logic                            redirect,
  input  logic [ADDR_WIDTH-1:0]           redirect_pc,
  output logic [WORD_SIZE-1:0]            ir,
  output logic [ADDR_WIDTH-1:0]           ir_pc,
  output logic                            ir_valid,
  input  logic                            ir_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                     fetch_words,
  output logic [31:0]                     stall_cycles
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [WORD_SIZE-1:0]  r_word [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr [FIFO_DEPTH];

  logic w_issue;
  logic w_pop;
  logic w_nonempty;

  // Issue only from RUN with free space counted before this cycle's pop;
  // reset is folded in so the strobes are low while rst is held.
  assign w_issue    = !rst && (r_state == RUN) && !halt && bus_gnt && !redirect &&
                      (r_count < CW'(FIFO_DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && ir_ready;

  assign mem_addr   = r_pc;
  assign mem_en     = w_issue;
  assign mem_rd     = w_issue;
  assign mem_wr     = 1'b0;

  assign ir_valid   = w_nonempty;
  assign ir         = w_nonempty ? r_word[r_rptr] : '0;
  assign ir_pc      = w_nonempty ? r_addr[r_rptr] : '0;
  assign fifo_count = r_count;

  // Control: state, pc, occupancy and pointers; redirect beats push/pop/halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= ADDR_WIDTH'(RESET_PC);
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect) begin
      r_pc    <= redirect_pc;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= halt ? HOLD : RUN;
      if (w_issue) begin
        r_pc   <= r_pc + 1'b1;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage: captures the returned word and its address at the write pointer.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_word[r_wptr] <= mem_data;
      r_addr[r_wptr] <= r_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic w_stall;
  assign w_stall = !rst && (r_state == RUN) && !halt && !redirect && !w_issue;

  // Statistics: free-running, only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_words  <= '0;
      stall_cycles <= '0;
    end else begin
      if (w_issue) fetch_words  <= fetch_words + 1'b1;
      if (w_stall) stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized + directed bench for fetch_unit. A queue-based
// reference model pushes expected {word, pc} entries at each fetch; a monitor
// pops and compares when the DUT hands over an instruction.
module tb_fetch_unit;

  localparam int WS = 32;
  localparam int AW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [WS-1:0] mem_data;
  logic          mem_en, mem_rd, mem_wr;
  logic          bus_gnt = 1'b0, halt = 1'b0, redirect = 1'b0, ir_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [WS-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic [2:0]    fifo_count;
`ifdef FETCH_STATS_EN
  logic [31:0]   fetch_words, stall_cycles;
  logic [31:0]   m_fw, m_st;
`endif

  fetch_unit #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .FIFO_DEPTH(D), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_gnt(bus_gnt),
    .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .fifo_count(fifo_count)
`ifdef FETCH_STATS_EN
    , .fetch_words(fetch_words), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WS-1:0] memf(input logic [AW-1:0] a);
    return {~a, a} ^ 32'h1357_9BDF;
  endfunction

  // Memory returns garbage unless strobed, so a push without issue shows up.
  assign mem_data = (mem_en && mem_rd) ? memf(mem_addr) : 32'hDEAD_BEEF;

  typedef struct { logic [WS-1:0] w; logic [AW-1:0] a; } ent_t;
  ent_t          sb[$];
  int            m_count = 0;
  logic [AW-1:0] m_pc = '0;
  bit            m_hold = 0;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_issue();
    return !rst && !m_hold && !halt && bus_gnt && !redirect && (m_count < D);
  endfunction

  // Reference model: advances at each clock edge from the inputs it sees.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      sb.delete(); m_count = 0; m_pc = '0; m_hold = 0;
`ifdef FETCH_STATS_EN
      m_fw = 0; m_st = 0;
`endif
    end else begin
      automatic bit iss = exp_issue();
      automatic bit pop = (m_count > 0) && ir_ready;
`ifdef FETCH_STATS_EN
      if (iss) m_fw++;
      if (!m_hold && !halt && !redirect && !iss) m_st++;
`endif
      if (redirect) begin
        sb.delete(); m_count = 0; m_pc = redirect_pc;
      end else begin
        if (pop) m_count--;
        if (iss) begin
          sb.push_back('{w: memf(m_pc), a: m_pc});
          m_count++;
          m_pc++;
        end
        m_hold = halt;
      end
    end
  end

  // Monitor: samples mid-cycle, checks strobes and pops on each handover.
  initial forever begin
    @(negedge clk);
    chk("mem_en", mem_en, exp_issue());
    chk("mem_rd", mem_rd, exp_issue());
    chk("mem_wr", mem_wr, 0);
    chk("mem_addr", mem_addr, m_pc);
    chk("fifo_count", fifo_count, m_count);
    chk("ir_valid", ir_valid, m_count != 0);
    if (m_count == 0) begin
      chk("ir_idle", ir, 0);
      chk("ir_pc_idle", ir_pc, 0);
    end
`ifdef FETCH_STATS_EN
    chk("fetch_words", fetch_words, m_fw);
    chk("stall_cycles", stall_cycles, m_st);
`endif
    if (ir_valid && ir_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        automatic ent_t e = sb.pop_front();
        chk("ir", ir, e.w);
        chk("ir_pc", ir_pc, e.a);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Streaming from reset with no bubbles.
    step(2);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    bus_gnt = 1; ir_ready = 1;
    rst = 0;
    step(1);
    chk("first_addr", mem_addr, 1);
    chk("first_valid", ir_valid, 1);
    chk("first_ir_pc", ir_pc, 0);
    chk("first_ir", ir, memf(16'd0));
    step(10);

    // Backpressure fills the FIFO, then resumes.
    ir_ready = 0;
    step(8);
    chk("full_count", fifo_count, 4);
    chk("full_mem_en", mem_en, 0);
    ir_ready = 1;
    step(6);

    // Redirect with 3 entries queued.
    ir_ready = 0; redirect = 1; redirect_pc = 16'h0040;
    step(1);
    redirect = 0;
    step(3);
    chk("three_queued", fifo_count, 3);
    redirect = 1; redirect_pc = 16'h0100;
    step(1);
    redirect = 0;
    chk("redir_valid", ir_valid, 0);
    chk("redir_addr", mem_addr, 16'h0100);
    step(1);
    chk("redir_ir_pc", ir_pc, 16'h0100);
    ir_ready = 1;
    step(4);

    // PC wrap.
    redirect = 1; redirect_pc = 16'hFFFE;
    step(1);
    redirect = 0;
    step(6);

    // Grant stall then halt while queue drains.
    ir_ready = 0;
    step(3);
    ir_ready = 1; bus_gnt = 0;
`ifdef FETCH_STATS_EN
    begin
      automatic logic [31:0] s0 = stall_cycles;
      step(3);
      chk("stall_gnt", stall_cycles, s0 + 3);
      bus_gnt = 1; halt = 1;
      step(2);
      chk("stall_halt", stall_cycles, s0 + 3);
    end
`else
    step(3);
    bus_gnt = 1; halt = 1;
    step(2);
`endif
    halt = 0;
    step(4);

    // Reset mid-stream with 2 entries queued.
    ir_ready = 0;
    redirect = 1; redirect_pc = 16'h0200;
    step(1);
    redirect = 0;
    step(2);
    chk("two_queued", fifo_count, 2);
    rst = 1;
    #1;
    chk("arst_valid", ir_valid, 0);
    chk("arst_ir", ir, 0);
    chk("arst_ir_pc", ir_pc, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_mem_en", mem_en, 0);
    chk("arst_addr", mem_addr, 0);
    step(2);
    rst = 0; ir_ready = 1;
    step(1);
    chk("restart_ir_pc", ir_pc, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus_gnt     = ($urandom_range(0, 99) < 80);
      halt        = ($urandom_range(0, 99) < 10);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = AW'($urandom);
      if ($urandom_range(0, 9) == 0) redirect_pc = 16'hFFFD;
      ir_ready    = ($urandom_range(0, 99) < 65);
      step(1);
    end
    redirect = 0; halt = 0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
